// File: rtl/ascon_ti_perm_driver.sv
// Sharing front-end and round sequencer for the 3-share threshold Ascon core.
// Define ASCON_TI_SHARED_OUT_EN to output the core's result shares unrecombined.
module ascon_ti_perm_driver #(
    parameter int unsigned MAX_ROUNDS = 12,
    parameter logic [63:0] LFSR_INIT  = 64'h0123456789ABCDEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] state_in,
    input  logic [639:0] mask_in,
    input  logic [4:0]   rounds_in,
    input  logic         seed_we,
    input  logic [63:0]  seed,
    output logic         perm_reset,
    output logic         perm_start,
    output logic [4:0]   perm_ctr,
    output logic [4:0]   perm_rounds,
    output logic [319:0] S_0,
    output logic [319:0] S_1,
    output logic [319:0] S_2,
    output logic [63:0]  r0,
    output logic [63:0]  r1,
    output logic [63:0]  r2,
    output logic [63:0]  r3,
    output logic [63:0]  r4,
    output logic [63:0]  r5,
    output logic [63:0]  r6,
    input  logic [319:0] out_0,
    input  logic [319:0] out_1,
    input  logic [319:0] out_2,
    input  logic         perm_done,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef ASCON_TI_SHARED_OUT_EN
    output logic [319:0] res_0,
    output logic [319:0] res_1,
    output logic [319:0] res_2
`else
    output logic [319:0] res
`endif
);

    localparam logic [63:0] FB = 64'hD800000000000000;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, OUT} state_t;

    state_t      state, state_nxt;
    logic [4:0]  ctr_nxt;
    logic [4:0]  r_clamp;
    logic        accept, adv, capture, seed_ld;
    logic        rst_q1, rst_q2;
    logic [63:0] lfsr [7];
    logic [63:0] seeded [7];

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} << n;
        return d[127:64];
    endfunction

    function automatic logic [63:0] step(input logic [63:0] v);
        return {1'b0, v[63:1]} ^ (v[0] ? FB : 64'd0);
    endfunction

    // Core reset stays high one full cycle past the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_q1 <= 1'b0;
            rst_q2 <= 1'b0;
        end else begin
            rst_q1 <= 1'b1;
            rst_q2 <= rst_q1;
        end
    end

    assign perm_reset = ~rst_q2;
    assign in_ready   = (state == IDLE) && rst_q1;
    assign accept     = in_valid && in_ready;
    assign seed_ld    = seed_we && (state == IDLE);
    assign out_valid  = (state == OUT);

    assign r_clamp = (rounds_in == 5'd0 || 32'(rounds_in) > MAX_ROUNDS)
                   ? 5'(MAX_ROUNDS) : rounds_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ctr_nxt    = perm_ctr;
        perm_start = 1'b0;
        adv        = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                    ctr_nxt   = 5'd0;
                end
            end
            LOAD: begin
                perm_start = 1'b1;
                adv        = 1'b1;
                ctr_nxt    = 5'd1;
                state_nxt  = RUN;
            end
            RUN: begin
                perm_start = 1'b1;
                adv        = 1'b1;
                if (perm_ctr == perm_rounds) state_nxt = DRAIN;
                else ctr_nxt = perm_ctr + 5'd1;
            end
            DRAIN: begin
                if (perm_done) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perm_ctr    <= 5'd0;
            perm_rounds <= 5'd0;
            S_0         <= '0;
            S_1         <= '0;
            S_2         <= '0;
        end else begin
            perm_ctr <= ctr_nxt;
            if (accept) begin
                perm_rounds <= r_clamp;
                S_0 <= state_in ^ mask_in[639:320] ^ mask_in[319:0];
                S_1 <= mask_in[639:320];
                S_2 <= mask_in[319:0];
            end
        end
    end

`ifdef ASCON_TI_SHARED_OUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_0 <= '0;
            res_1 <= '0;
            res_2 <= '0;
        end else if (capture) begin
            res_0 <= out_0;
            res_1 <= out_1;
            res_2 <= out_2;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       res <= '0;
        else if (capture) res <= out_0 ^ out_1 ^ out_2;
    end
`endif

    // A zero seed would lock a Galois LFSR, so it is replaced by 1
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            seeded[i] = rotl(seed, 8 * i);
            if (seeded[i] == 64'd0) seeded[i] = 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 7; i++) lfsr[i] <= rotl(LFSR_INIT, 8 * i);
        end else if (seed_ld) begin
            for (int i = 0; i < 7; i++) lfsr[i] <= seeded[i];
        end else if (adv) begin
            for (int i = 0; i < 7; i++) lfsr[i] <= step(lfsr[i]);
        end
    end

    assign r0 = lfsr[0];
    assign r1 = lfsr[1];
    assign r2 = lfsr[2];
    assign r3 = lfsr[3];
    assign r4 = lfsr[4];
    assign r5 = lfsr[5];
    assign r6 = lfsr[6];

endmodule

// File: tb/tb_ascon_ti_perm_driver.sv
// Bench for ascon_ti_perm_driver with a behavioural Ascon core and LFSR model.
// Vector table plus random operations, reset and backpressure sequences.
module tb_ascon_ti_perm_driver;

    localparam logic [63:0] FB   = 64'hD800000000000000;
    localparam logic [63:0] INIT = 64'h0123456789ABCDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, seed_we;
    logic [319:0] state_in;
    logic [639:0] mask_in;
    logic [4:0]   rounds_in;
    logic [63:0]  seed;
    logic         perm_reset, perm_start;
    logic [4:0]   perm_ctr, perm_rounds;
    logic [319:0] S_0, S_1, S_2;
    logic [63:0]  r0, r1, r2, r3, r4, r5, r6;
    logic [319:0] out_0 = '0, out_1 = '0, out_2 = '0;
    logic         perm_done = 1'b0;
    logic         out_valid, out_ready;
    logic [319:0] got_res;

    ascon_ti_perm_driver dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .mask_in(mask_in),
        .rounds_in(rounds_in),
        .seed_we(seed_we), .seed(seed),
        .perm_reset(perm_reset), .perm_start(perm_start),
        .perm_ctr(perm_ctr), .perm_rounds(perm_rounds),
        .S_0(S_0), .S_1(S_1), .S_2(S_2),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .r4(r4), .r5(r5), .r6(r6),
        .out_0(out_0), .out_1(out_1), .out_2(out_2),
        .perm_done(perm_done),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef ASCON_TI_SHARED_OUT_EN
        .res_0(res_0), .res_1(res_1), .res_2(res_2)
`else
        .res(got_res)
`endif
    );

`ifdef ASCON_TI_SHARED_OUT_EN
    logic [319:0] res_0, res_1, res_2;
    assign got_res = res_0 ^ res_1 ^ res_2;
`endif

    logic [63:0] rv [7];
    assign rv[0] = r0;
    assign rv[1] = r1;
    assign rv[2] = r2;
    assign rv[3] = r3;
    assign rv[4] = r4;
    assign rv[5] = r5;
    assign rv[6] = r6;

    int checks = 0;
    int errors = 0;
    logic [63:0] mr [7];

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (n == 0) ? v : ((v << n) | (v >> (64 - n)));
    endfunction

    // Reference Ascon-pR: the last R rounds of the 12-round schedule
    function automatic logic [319:0] ascon(input logic [319:0] s, input int rn);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        if (rn > 12) rn = 12;
        if (rn < 0) rn = 0;
        for (int i = 12 - rn; i < 12; i++) begin
            x2 ^= 64'((15 - i) * 16 + i);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
            t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1) ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7) ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [63:0] lstep(input logic [63:0] v);
        return (v >> 1) ^ (v[0] ? FB : 64'd0);
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int clampr(input logic [4:0] r);
        return (r == 0 || r > 12) ? 12 : int'(r);
    endfunction

    task automatic chk(input string nm, input logic [319:0] a, input logic [319:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) mr[i] = rotl(INIT, 8 * i);
    endtask

    task automatic model_seed(input logic [63:0] s);
        for (int i = 0; i < 7; i++) begin
            mr[i] = rotl(s, 8 * i);
            if (mr[i] == 0) mr[i] = 64'd1;
        end
    endtask

    task automatic chk_lfsr(input string nm);
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s_r%0d", nm, i), 320'(rv[i]), 320'(mr[i]));
    endtask

    // Behavioural core: result shares and done one cycle after start falls
    logic block_done = 1'b0;
    logic start_d = 1'b0;
    logic [319:0] cp, ca, cb;
    always @(posedge clk) begin
        start_d   <= perm_start;
        perm_done <= 1'b0;
        if (start_d && !perm_start && !block_done) begin
            ca = rnd320();
            cb = rnd320();
            cp = ascon(S_0 ^ S_1 ^ S_2, int'(perm_rounds));
            out_0     <= cp ^ ca ^ cb;
            out_1     <= ca;
            out_2     <= cb;
            perm_done <= 1'b1;
        end
    end

    typedef struct {
        logic [319:0] st;
        logic [639:0] mk;
        logic [4:0]   rin;
        int           er;
        int           hold;
    } vec_t;

    task automatic send(input logic [319:0] st, input logic [639:0] mk,
                        input logic [4:0] rin, output bit ok);
        int w = 0;
        in_valid  = 1'b1;
        state_in  = st;
        mask_in   = mk;
        rounds_in = rin;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 50);
        if (!ok) begin
            in_valid = 1'b0;
            chk("accept_timeout", 320'(w), 320'(0));
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string nm, input vec_t t);
        bit ok;
        int lat;
        logic [319:0] exp_res, seq, eseq, held;
        send(t.st, t.mk, t.rin, ok);
        if (!ok) return;
        exp_res = ascon(t.st, t.er);
        chk({nm, "_s0"}, S_0, t.st ^ t.mk[639:320] ^ t.mk[319:0]);
        chk({nm, "_s1"}, S_1, t.mk[639:320]);
        chk({nm, "_s2"}, S_2, t.mk[319:0]);
        chk({nm, "_rounds"}, 320'(perm_rounds), 320'(t.er));
        seq  = '0;
        eseq = '0;
        for (int k = 0; k <= t.er; k++) eseq = (eseq << 5) | 320'(k);
        eseq = (eseq << 5) | 320'(t.er);
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (perm_start || lat == t.er + 1) seq = (seq << 5) | 320'(perm_ctr);
            if (lat == 1) chk({nm, "_r0_load"}, 320'(r0), 320'(lstep(mr[0])));
            @(negedge clk);
            lat++;
        end
        chk({nm, "_ctr_seq"}, seq, eseq);
        chk({nm, "_latency"}, 320'(lat), 320'(t.er + 3));
        if (!out_valid) return;
        chk({nm, "_res"}, got_res, exp_res);
        for (int k = 0; k <= t.er; k++)
            for (int i = 0; i < 7; i++) mr[i] = lstep(mr[i]);
        chk_lfsr(nm);
        held = got_res;
        for (int h = 0; h < t.hold; h++) begin
            in_valid  = 1'b1;
            state_in  = rnd320();
            rounds_in = 5'd2;
            seed_we   = 1'b1;
            seed      = {$urandom, $urandom};
            @(negedge clk);
            chk({nm, "_bp_valid"}, 320'(out_valid), 320'(1));
            chk({nm, "_bp_res"}, got_res, held);
            chk({nm, "_bp_ready"}, 320'(in_ready), 320'(0));
            chk({nm, "_bp_start"}, 320'(perm_start), 320'(0));
        end
        in_valid  = 1'b0;
        seed_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_hs_valid"}, 320'(out_valid), 320'(0));
        chk({nm, "_hs_ready"}, 320'(in_ready), 320'(1));
        if (t.hold > 0) chk_lfsr({nm, "_bp"});
    endtask

    vec_t tv [8];
    vec_t rt;
    logic [319:0] same_st;
    logic [63:0]  sd;
    bit           ok;

    initial begin
        same_st = rnd320();
        tv[0] = '{320'd0, {rnd320(), rnd320()}, 5'd12, 12, 0};
        tv[1] = '{rnd320(), {rnd320(), rnd320()}, 5'd6, 6, 0};
        tv[2] = '{rnd320(), {rnd320(), rnd320()}, 5'd0, 12, 0};
        tv[3] = '{same_st, {640{1'b0}}, 5'd3, 3, 0};
        tv[4] = '{same_st, {640{1'b1}}, 5'd3, 3, 0};
        tv[5] = '{rnd320(), {rnd320(), rnd320()}, 5'd13, 12, 0};
        tv[6] = '{rnd320(), {rnd320(), rnd320()}, 5'd31, 12, 10};
        tv[7] = '{rnd320(), {rnd320(), rnd320()}, 5'd1, 1, 0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        state_in  = '0;
        mask_in   = '0;
        rounds_in = '0;
        seed_we   = 1'b0;
        seed      = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 320'(in_ready), 320'(0));
        chk("rst_perm_reset", 320'(perm_reset), 320'(1));
        chk("rst_out_valid", 320'(out_valid), 320'(0));
        chk("rst_start", 320'(perm_start), 320'(0));
        chk("rst_ctr", 320'(perm_ctr), 320'(0));
        chk("rst_rounds", 320'(perm_rounds), 320'(0));
        chk("rst_shares", S_0 | S_1 | S_2, 320'd0);
        chk("rst_res", got_res, 320'd0);
        chk_lfsr("rst");
        reset = 1'b1;
        @(negedge clk);
        chk("rel_perm_reset_hi", 320'(perm_reset), 320'(1));
        chk("rel_in_ready", 320'(in_ready), 320'(1));
        @(negedge clk);
        chk("rel_perm_reset_lo", 320'(perm_reset), 320'(0));

        seed_we = 1'b1;
        seed    = 64'd0;
        @(negedge clk);
        seed_we = 1'b0;
        model_seed(64'd0);
        chk_lfsr("seed0");

        for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), tv[i]);

        sd      = {$urandom, $urandom};
        seed_we = 1'b1;
        seed    = sd;
        @(negedge clk);
        seed_we = 1'b0;
        model_seed(sd);
        chk_lfsr("seedr");

        // Core never answers: DRAIN must hold until an async reset clears it
        block_done = 1'b1;
        send(rnd320(), {rnd320(), rnd320()}, 5'd4, ok);
        repeat (20) @(negedge clk);
        chk("hang_valid", 320'(out_valid), 320'(0));
        chk("hang_ctr", 320'(perm_ctr), 320'(4));
        chk("hang_start", 320'(perm_start), 320'(0));
        reset = 1'b0;
        #1;
        chk("mid_in_ready", 320'(in_ready), 320'(0));
        chk("mid_perm_reset", 320'(perm_reset), 320'(1));
        chk("mid_out_valid", 320'(out_valid), 320'(0));
        chk("mid_ctr", 320'(perm_ctr), 320'(0));
        chk("mid_s0", S_0, 320'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        block_done = 1'b0;
        chk("mid_perm_reset_lo", 320'(perm_reset), 320'(0));
        chk_lfsr("mid");

        for (int n = 0; n < 8; n++) begin
            rt.st   = rnd320();
            rt.mk   = {rnd320(), rnd320()};
            rt.rin  = 5'($urandom_range(0, 31));
            rt.er   = clampr(rt.rin);
            rt.hold = $urandom_range(0, 3);
            do_op($sformatf("rnd%0d", n), rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
